// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory port between the I-cache and D-cache miss
//   buses. One transfer is in flight at a time. The D-cache has priority.
//   An anti-starvation counter forces an I grant after STARVE_LIMIT
//   consecutive D grants that were made while I was waiting. A per-transfer
//   timeout aborts the transfer and returns ERR_DATA. Both sides use a
//   4-phase req/ack handshake.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no owner; arbitrates whenever any req[65] is high
//   XFER_D  | D-cache command on the memory bus, waiting for ack/timeout
//   XFER_I  | I-cache command on the memory bus, waiting for ack/timeout
//   RELEASE | owner's rsp ack held until the owner drops its req
//
// Ports
//   Clk, Rst     clock; synchronous active-high reset
//   Icache_req   [65] req, [64] we, [63:32] addr, [31:0] wdata
//   Icache_rsp   [32] ack, [31:0] rdata
//   Dcache_req   same format as Icache_req
//   Dcache_rsp   same format as Icache_rsp
//   Mem_bus_out  request to memory, same format as Icache_req
//   Mem_bus_in   [32] ack (1-cycle pulse), [31:0] rdata
//   o_grant      one-hot owner: [1] D, [0] I; 00 when idle
//   o_timeout    sticky timeout flag, cleared only by Rst
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [65:0] Icache_req,
  output logic [32:0] Icache_rsp,
  input  logic [65:0] Dcache_req,
  output logic [32:0] Dcache_rsp,
  output logic [65:0] Mem_bus_out,
  input  logic [32:0] Mem_bus_in,
  output logic [1:0]  o_grant,
  output logic        o_timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] XFER_D  = 2'd1;
  localparam logic [1:0] XFER_I  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [3:0]  starve_cnt;
  logic [9:0]  tmo_cnt;
  logic        i_req;
  logic        d_req;
  logic        i_wins;
  logic        owner_req;
  logic        xfer_done;
  logic [32:0] xfer_rsp;

  assign i_req     = Icache_req[65];
  assign d_req     = Dcache_req[65];
  assign i_wins    = i_req && (!d_req || (starve_cnt == STARVE_MAX));
  assign owner_req = o_grant[1] ? d_req : i_req;
  // A real ack wins over a timeout landing in the same cycle.
  assign xfer_done = Mem_bus_in[32] || (tmo_cnt == TMO_LAST);
  assign xfer_rsp  = Mem_bus_in[32] ? {1'b1, Mem_bus_in[31:0]} : {1'b1, ERR_DATA};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      tmo_cnt     <= '0;
      Icache_rsp  <= '0;
      Dcache_rsp  <= '0;
      Mem_bus_out <= '0;
      o_grant     <= '0;
      o_timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!i_req) starve_cnt <= '0;
          if (i_req || d_req) begin
            tmo_cnt <= '0;
            if (i_wins) begin
              Mem_bus_out <= Icache_req;
              o_grant     <= 2'b01;
              starve_cnt  <= '0;
              state       <= XFER_I;
            end else begin
              Mem_bus_out <= Dcache_req;
              o_grant     <= 2'b10;
              state       <= XFER_D;
              if (i_req && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        XFER_D, XFER_I: begin
          if (xfer_done) begin
            Mem_bus_out <= '0;
            state       <= RELEASE;
            if (state == XFER_D) Dcache_rsp <= xfer_rsp;
            else                 Icache_rsp <= xfer_rsp;
            if (!Mem_bus_in[32]) o_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 10'd1;
          end
        end
        RELEASE: begin
          if (!owner_req) begin
            Icache_rsp <= '0;
            Dcache_rsp <= '0;
            o_grant    <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [65:0] Icache_req = '0;
  logic [65:0] Dcache_req = '0;
  logic [32:0] Mem_bus_in = '0;
  logic [32:0] Icache_rsp;
  logic [32:0] Dcache_rsp;
  logic [65:0] Mem_bus_out;
  logic [1:0]  o_grant;
  logic        o_timeout;

  int n_pass  = 0;
  int n_total = 0;

  logic [65:0] exp_mem[$];
  logic [32:0] exp_rsp[$];
  logic [1:0]  exp_owner[$];

  mem_bus_arbiter #(
    .STARVE_LIMIT(4),
    .TIMEOUT(255),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .Icache_req(Icache_req),
    .Icache_rsp(Icache_rsp),
    .Dcache_req(Dcache_req),
    .Dcache_rsp(Dcache_rsp),
    .Mem_bus_out(Mem_bus_out),
    .Mem_bus_in(Mem_bus_in),
    .o_grant(o_grant),
    .o_timeout(o_timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic wait_mem_req(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (Mem_bus_out[65] === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge Clk);
    end
  endtask

  // Drives a one-cycle memory ack; returns at the negedge where the
  // registered response is visible.
  task automatic mem_ack(input logic [31:0] d);
    Mem_bus_in = {1'b1, d};
    @(negedge Clk);
    Mem_bus_in = '0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    step(2);
    n_total++; if (o_grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", o_grant); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", o_timeout); else n_pass++;
    n_total++; if (Mem_bus_out !== 66'd0) $display("FAIL reset_mem_out: got %h want 0", Mem_bus_out); else n_pass++;
    n_total++; if (Icache_rsp !== 33'd0) $display("FAIL reset_irsp: got %h want 0", Icache_rsp); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL reset_drsp: got %h want 0", Dcache_rsp); else n_pass++;
    Rst = 1'b0;
    step(1);
  endtask

  task automatic test_single_d_read();
    logic [65:0] em;
    logic [32:0] er;
    exp_mem.push_back({1'b1, 1'b0, 32'h100, 32'h0});
    Dcache_req = {1'b1, 1'b0, 32'h100, 32'h0};
    step(1);
    em = exp_mem.pop_front();
    n_total++; if (Mem_bus_out !== em) $display("FAIL d_read_cmd: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (o_grant !== 2'b10) $display("FAIL d_read_grant: got %b want 10", o_grant); else n_pass++;
    step(2);
    n_total++; if (Mem_bus_out !== em) $display("FAIL d_read_cmd_stable: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL d_read_early_rsp: got %h want 0", Dcache_rsp); else n_pass++;
    exp_rsp.push_back({1'b1, 32'h1234_5678});
    mem_ack(32'h1234_5678);
    er = exp_rsp.pop_front();
    n_total++; if (Dcache_rsp !== er) $display("FAIL d_read_rsp: got %h want %h", Dcache_rsp, er); else n_pass++;
    n_total++; if (Mem_bus_out[65] !== 1'b0) $display("FAIL d_read_mem_drop: got %b want 0", Mem_bus_out[65]); else n_pass++;
    step(2);
    n_total++; if (Dcache_rsp !== er) $display("FAIL d_read_rsp_held: got %h want %h", Dcache_rsp, er); else n_pass++;
    Dcache_req[65] = 1'b0;
    step(1);
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL d_read_rsp_release: got %h want 0", Dcache_rsp); else n_pass++;
    n_total++; if (o_grant !== 2'b00) $display("FAIL d_read_grant_release: got %b want 00", o_grant); else n_pass++;
    step(1);
  endtask

  task automatic test_simultaneous();
    logic [65:0] ci;
    logic [65:0] cd;
    logic [65:0] em;
    logic [32:0] er;
    ci = {1'b1, 1'b0, 32'h200, 32'h0};
    cd = {1'b1, 1'b0, 32'h300, 32'h0};
    exp_mem.push_back(cd);
    exp_mem.push_back(ci);
    Icache_req = ci;
    Dcache_req = cd;
    step(1);
    em = exp_mem.pop_front();
    n_total++; if (Mem_bus_out !== em) $display("FAIL sim_first_cmd: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (o_grant !== 2'b10) $display("FAIL sim_first_grant: got %b want 10", o_grant); else n_pass++;
    exp_rsp.push_back({1'b1, 32'hD0D0_0001});
    mem_ack(32'hD0D0_0001);
    er = exp_rsp.pop_front();
    n_total++; if (Dcache_rsp !== er) $display("FAIL sim_d_rsp: got %h want %h", Dcache_rsp, er); else n_pass++;
    n_total++; if (Icache_rsp !== 33'd0) $display("FAIL sim_i_rsp_quiet: got %h want 0", Icache_rsp); else n_pass++;
    Dcache_req[65] = 1'b0;
    step(1);
    n_total++; if (o_grant !== 2'b00) $display("FAIL sim_idle_grant: got %b want 00", o_grant); else n_pass++;
    step(1);
    em = exp_mem.pop_front();
    n_total++; if (Mem_bus_out !== em) $display("FAIL sim_second_cmd: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (o_grant !== 2'b01) $display("FAIL sim_second_grant: got %b want 01", o_grant); else n_pass++;
    exp_rsp.push_back({1'b1, 32'h1111_0002});
    mem_ack(32'h1111_0002);
    er = exp_rsp.pop_front();
    n_total++; if (Icache_rsp !== er) $display("FAIL sim_i_rsp: got %h want %h", Icache_rsp, er); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL sim_d_rsp_quiet: got %h want 0", Dcache_rsp); else n_pass++;
    Icache_req[65] = 1'b0;
    step(2);
  endtask

  task automatic test_starvation();
    bit          ok;
    logic [1:0]  eo;
    logic [31:0] d;
    logic [32:0] er;
    logic [32:0] got;
    Icache_req = {1'b1, 1'b0, 32'h400, 32'h0};
    Dcache_req = {1'b1, 1'b0, 32'h500, 32'h0};
    for (int k = 0; k < 4; k++) exp_owner.push_back(2'b10);
    exp_owner.push_back(2'b01);
    exp_owner.push_back(2'b10);
    for (int j = 0; j < 6; j++) begin
      wait_mem_req(10, ok);
      n_total++;
      if (!ok) begin
        $display("FAIL starve_req_wait[%0d]: got no mem req want mem req", j);
        break;
      end else n_pass++;
      eo = exp_owner.pop_front();
      n_total++; if (o_grant !== eo) $display("FAIL starve_order[%0d]: got %b want %b", j, o_grant, eo); else n_pass++;
      d = 32'hC0DE_0000 + 32'(j);
      exp_rsp.push_back({1'b1, d});
      mem_ack(d);
      er  = exp_rsp.pop_front();
      got = (eo == 2'b10) ? Dcache_rsp : Icache_rsp;
      n_total++; if (got !== er) $display("FAIL starve_rsp[%0d]: got %h want %h", j, got, er); else n_pass++;
      if (eo == 2'b10) begin
        Dcache_req[65] = 1'b0;
        step(1);
        if (j < 5) Dcache_req[65] = 1'b1;
      end else begin
        Icache_req[65] = 1'b0;
        step(1);
      end
    end
    exp_owner.delete();
    exp_rsp.delete();
    Icache_req = '0;
    Dcache_req = '0;
    step(2);
  endtask

  task automatic test_timeout();
    int          cnt;
    logic [32:0] er;
    Dcache_req = {1'b1, 1'b0, 32'h600, 32'h0};
    step(1);
    n_total++; if (o_grant !== 2'b10) $display("FAIL tmo_grant: got %b want 10", o_grant); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL tmo_flag_early: got %b want 0", o_timeout); else n_pass++;
    cnt = 0;
    while (Dcache_rsp[32] !== 1'b1 && cnt < 400) begin
      step(1);
      cnt++;
    end
    n_total++; if (cnt !== 255) $display("FAIL tmo_cycles: got %0d want 255", cnt); else n_pass++;
    exp_rsp.push_back({1'b1, 32'hDEAD_BEEF});
    er = exp_rsp.pop_front();
    n_total++; if (Dcache_rsp !== er) $display("FAIL tmo_rsp: got %h want %h", Dcache_rsp, er); else n_pass++;
    n_total++; if (o_timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", o_timeout); else n_pass++;
    n_total++; if (Mem_bus_out[65] !== 1'b0) $display("FAIL tmo_mem_drop: got %b want 0", Mem_bus_out[65]); else n_pass++;
    mem_ack(32'h1111_1111);
    n_total++; if (Dcache_rsp !== er) $display("FAIL tmo_late_ack_release: got %h want %h", Dcache_rsp, er); else n_pass++;
    Dcache_req[65] = 1'b0;
    step(1);
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL tmo_release_rsp: got %h want 0", Dcache_rsp); else n_pass++;
    n_total++; if (o_grant !== 2'b00) $display("FAIL tmo_release_grant: got %b want 00", o_grant); else n_pass++;
    mem_ack(32'h2222_2222);
    n_total++; if (Mem_bus_out !== 66'd0) $display("FAIL tmo_idle_ack_mem: got %h want 0", Mem_bus_out); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL tmo_idle_ack_rsp: got %h want 0", Dcache_rsp); else n_pass++;
    n_total++; if (o_timeout !== 1'b1) $display("FAIL tmo_flag_sticky: got %b want 1", o_timeout); else n_pass++;
    step(1);
  endtask

  task automatic test_write_i();
    logic [65:0] ci;
    logic [65:0] em;
    logic [32:0] er;
    ci = {1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5};
    exp_mem.push_back(ci);
    Icache_req = ci;
    step(1);
    em = exp_mem.pop_front();
    n_total++; if (Mem_bus_out !== em) $display("FAIL wr_cmd: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (o_grant !== 2'b01) $display("FAIL wr_grant: got %b want 01", o_grant); else n_pass++;
    step(3);
    n_total++; if (Mem_bus_out !== em) $display("FAIL wr_cmd_stable: got %h want %h", Mem_bus_out, em); else n_pass++;
    exp_rsp.push_back({1'b1, 32'h0BAD_F00D});
    mem_ack(32'h0BAD_F00D);
    er = exp_rsp.pop_front();
    n_total++; if (Icache_rsp !== er) $display("FAIL wr_rsp: got %h want %h", Icache_rsp, er); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL wr_d_quiet: got %h want 0", Dcache_rsp); else n_pass++;
    Icache_req[65] = 1'b0;
    step(2);
  endtask

  task automatic test_reset_mid();
    logic [65:0] ci;
    logic [65:0] em;
    logic [32:0] er;
    ci = {1'b1, 1'b0, 32'h800, 32'h0};
    Dcache_req = {1'b1, 1'b0, 32'h700, 32'h0};
    step(1);
    n_total++; if (o_grant !== 2'b10) $display("FAIL rmid_grant_d: got %b want 10", o_grant); else n_pass++;
    step(1);
    Rst = 1'b1;
    Dcache_req = '0;
    Icache_req = ci;
    step(1);
    n_total++; if (o_grant !== 2'b00) $display("FAIL rmid_grant: got %b want 00", o_grant); else n_pass++;
    n_total++; if (o_timeout !== 1'b0) $display("FAIL rmid_timeout: got %b want 0", o_timeout); else n_pass++;
    n_total++; if (Mem_bus_out !== 66'd0) $display("FAIL rmid_mem_out: got %h want 0", Mem_bus_out); else n_pass++;
    n_total++; if (Dcache_rsp !== 33'd0) $display("FAIL rmid_drsp: got %h want 0", Dcache_rsp); else n_pass++;
    Rst = 1'b0;
    Mem_bus_in = {1'b1, 32'h3333_3333};
    exp_mem.push_back(ci);
    step(1);
    Mem_bus_in = '0;
    em = exp_mem.pop_front();
    n_total++; if (Mem_bus_out !== em) $display("FAIL rmid_i_cmd: got %h want %h", Mem_bus_out, em); else n_pass++;
    n_total++; if (o_grant !== 2'b01) $display("FAIL rmid_i_grant: got %b want 01", o_grant); else n_pass++;
    step(1);
    n_total++; if (Icache_rsp !== 33'd0) $display("FAIL rmid_stale_ack: got %h want 0", Icache_rsp); else n_pass++;
    n_total++; if (Mem_bus_out[65] !== 1'b1) $display("FAIL rmid_still_xfer: got %b want 1", Mem_bus_out[65]); else n_pass++;
    exp_rsp.push_back({1'b1, 32'h4444_4444});
    mem_ack(32'h4444_4444);
    er = exp_rsp.pop_front();
    n_total++; if (Icache_rsp !== er) $display("FAIL rmid_i_rsp: got %h want %h", Icache_rsp, er); else n_pass++;
    Icache_req[65] = 1'b0;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_d_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_write_i();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
